// File: rtl/mem_pipe_regs_if.sv
// mem_pipe_regs_if: bundles the execute-stage results, the data-memory
// response and the EX/DM and DM/WB pipeline-register outputs.
// The master side is whoever drives the execute stage and data memory;
// the slave side is the pipeline-register block itself.
interface mem_pipe_regs_if #(
   parameter int DW = 16,
   parameter int RW = 3
);
   logic          Done_DM;
   logic [DW-1:0] EX_ALU;
   logic [DW-1:0] EX_PC;
   logic [DW-1:0] EX_RTData;
   logic          EX_MemWrt;
   logic          EX_MemRead;
   logic          EX_nHaltSig;
   logic          EX_RegWrt;
   logic          EX_err;
   logic [RW-1:0] EX_RD;
   logic [1:0]    EX_RegSrc;
   logic [DW-1:0] MEM_readData;
   logic          MMEM_err;

   logic [DW-1:0] EXDM_ALU;
   logic [DW-1:0] EXDM_PC;
   logic [DW-1:0] EXDM_RTData;
   logic          EXDM_MemWrt;
   logic          EXDM_MemRead;
   logic          EXDM_HaltSig;
   logic          EXDM_RegWrt;
   logic          EXDM_err;
   logic [RW-1:0] EXDM_RD;
   logic [1:0]    EXDM_RegSrc;

   logic [DW-1:0] DMWB_ALU;
   logic [DW-1:0] DMWB_PC;
   logic [DW-1:0] DMWB_readData;
   logic          DMWB_RegWrt;
   logic [RW-1:0] DMWB_RD;
   logic [1:0]    DMWB_RegSrc;
   logic          FWB_err;
   logic          DMWB_err;

   modport master (
      output Done_DM, EX_ALU, EX_PC, EX_RTData, EX_MemWrt, EX_MemRead,
             EX_nHaltSig, EX_RegWrt, EX_err, EX_RD, EX_RegSrc,
             MEM_readData, MMEM_err,
      input  EXDM_ALU, EXDM_PC, EXDM_RTData, EXDM_MemWrt, EXDM_MemRead,
             EXDM_HaltSig, EXDM_RegWrt, EXDM_err, EXDM_RD, EXDM_RegSrc,
             DMWB_ALU, DMWB_PC, DMWB_readData, DMWB_RegWrt, DMWB_RD,
             DMWB_RegSrc, FWB_err, DMWB_err
   );

   modport slave (
      input  Done_DM, EX_ALU, EX_PC, EX_RTData, EX_MemWrt, EX_MemRead,
             EX_nHaltSig, EX_RegWrt, EX_err, EX_RD, EX_RegSrc,
             MEM_readData, MMEM_err,
      output EXDM_ALU, EXDM_PC, EXDM_RTData, EXDM_MemWrt, EXDM_MemRead,
             EXDM_HaltSig, EXDM_RegWrt, EXDM_err, EXDM_RD, EXDM_RegSrc,
             DMWB_ALU, DMWB_PC, DMWB_readData, DMWB_RegWrt, DMWB_RD,
             DMWB_RegSrc, FWB_err, DMWB_err
   );
endinterface

// File: rtl/mem_pipe_regs.sv
// mem_pipe_regs: EX/DM and DM/WB pipeline registers of the 16-bit core.
// Both stages advance together when the data memory reports Done_DM=1 and
// freeze otherwise. Every output comes straight from a flop.
// Optional feature macro: MEMWB_BUBBLE_EN -- when defined, a stalled edge
// clears DMWB_RegWrt and DMWB_err so a frozen writeback entry is not
// written back (or flagged) more than once.
module mem_pipe_regs #(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic               clk,
   input  logic               rst,
   mem_pipe_regs_if.slave     bus
);

   logic [DW-1:0] r_exdmAlu;
   logic [DW-1:0] r_exdmPc;
   logic [DW-1:0] r_exdmRtData;
   logic          r_exdmMemWrt;
   logic          r_exdmMemRead;
   logic          r_exdmHaltSig;
   logic          r_exdmRegWrt;
   logic          r_exdmErr;
   logic [RW-1:0] r_exdmRd;
   logic [1:0]    r_exdmRegSrc;

   logic [DW-1:0] r_dmwbAlu;
   logic [DW-1:0] r_dmwbPc;
   logic [DW-1:0] r_dmwbReadData;
   logic          r_dmwbRegWrt;
   logic [RW-1:0] r_dmwbRd;
   logic [1:0]    r_dmwbRegSrc;
   logic          r_fwbErr;
   logic          r_dmwbErr;

   // Reset clears both stages to a bubble; otherwise both stages shift
   // together on Done_DM and hold (optionally dropping writeback) when stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exdmAlu      <= '0;
         r_exdmPc       <= '0;
         r_exdmRtData   <= '0;
         r_exdmMemWrt   <= 1'b0;
         r_exdmMemRead  <= 1'b0;
         r_exdmHaltSig  <= 1'b0;
         r_exdmRegWrt   <= 1'b0;
         r_exdmErr      <= 1'b0;
         r_exdmRd       <= '0;
         r_exdmRegSrc   <= 2'b00;
         r_dmwbAlu      <= '0;
         r_dmwbPc       <= '0;
         r_dmwbReadData <= '0;
         r_dmwbRegWrt   <= 1'b0;
         r_dmwbRd       <= '0;
         r_dmwbRegSrc   <= 2'b00;
         r_fwbErr       <= 1'b0;
         r_dmwbErr      <= 1'b0;
      end else if (bus.Done_DM) begin
         r_exdmAlu      <= bus.EX_ALU;
         r_exdmPc       <= bus.EX_PC;
         r_exdmRtData   <= bus.EX_RTData;
         r_exdmMemWrt   <= bus.EX_MemWrt;
         r_exdmMemRead  <= bus.EX_MemRead;
         r_exdmHaltSig  <= bus.EX_nHaltSig;
         r_exdmRegWrt   <= bus.EX_RegWrt;
         r_exdmErr      <= bus.EX_err;
         r_exdmRd       <= bus.EX_RD;
         r_exdmRegSrc   <= bus.EX_RegSrc;
         r_dmwbAlu      <= r_exdmAlu;
         r_dmwbPc       <= r_exdmPc;
         r_dmwbReadData <= bus.MEM_readData;
         r_dmwbRegWrt   <= r_exdmRegWrt;
         r_dmwbRd       <= r_exdmRd;
         r_dmwbRegSrc   <= r_exdmRegSrc;
         r_fwbErr       <= r_exdmErr;
         r_dmwbErr      <= bus.MMEM_err;
      end
`ifdef MEMWB_BUBBLE_EN
      else begin
         r_dmwbRegWrt   <= 1'b0;
         r_dmwbErr      <= 1'b0;
      end
`else
`endif
   end

   assign bus.EXDM_ALU      = r_exdmAlu;
   assign bus.EXDM_PC       = r_exdmPc;
   assign bus.EXDM_RTData   = r_exdmRtData;
   assign bus.EXDM_MemWrt   = r_exdmMemWrt;
   assign bus.EXDM_MemRead  = r_exdmMemRead;
   assign bus.EXDM_HaltSig  = r_exdmHaltSig;
   assign bus.EXDM_RegWrt   = r_exdmRegWrt;
   assign bus.EXDM_err      = r_exdmErr;
   assign bus.EXDM_RD       = r_exdmRd;
   assign bus.EXDM_RegSrc   = r_exdmRegSrc;
   assign bus.DMWB_ALU      = r_dmwbAlu;
   assign bus.DMWB_PC       = r_dmwbPc;
   assign bus.DMWB_readData = r_dmwbReadData;
   assign bus.DMWB_RegWrt   = r_dmwbRegWrt;
   assign bus.DMWB_RD       = r_dmwbRd;
   assign bus.DMWB_RegSrc   = r_dmwbRegSrc;
   assign bus.FWB_err       = r_fwbErr;
   assign bus.DMWB_err      = r_dmwbErr;

endmodule

// File: tb/tb_mem_pipe_regs.sv
// tb_mem_pipe_regs: randomized and directed stimulus for mem_pipe_regs,
// checked against a history-based reference model: the EX/DM stage shows
// the most recently accepted execute record, the DM/WB stage shows the one
// accepted before it plus the memory response captured at the last advance.
module tb_mem_pipe_regs;

   typedef struct {
      logic [15:0] alu;
      logic [15:0] pc;
      logic [15:0] rt;
      logic        memWrt;
      logic        memRead;
      logic        halt;
      logic        regWrt;
      logic        err;
      logic [2:0]  rd;
      logic [1:0]  regSrc;
   } exRec_t;

   logic clk;
   logic rst;

   mem_pipe_regs_if #(.DW(16), .RW(3)) bus ();

   mem_pipe_regs #(.DW(16), .RW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checkCount;
   int errorCount;

   exRec_t      hist[$];
   logic [15:0] modelReadData;
   logic        modelMemErr;
   logic        modelStalledWb;

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic exRec_t sampleEx();
      exRec_t r;
      r.alu     = bus.EX_ALU;
      r.pc      = bus.EX_PC;
      r.rt      = bus.EX_RTData;
      r.memWrt  = bus.EX_MemWrt;
      r.memRead = bus.EX_MemRead;
      r.halt    = bus.EX_nHaltSig;
      r.regWrt  = bus.EX_RegWrt;
      r.err     = bus.EX_err;
      r.rd      = bus.EX_RD;
      r.regSrc  = bus.EX_RegSrc;
      return r;
   endfunction

   function automatic exRec_t zeroRec();
      exRec_t r;
      r.alu = '0; r.pc = '0; r.rt = '0; r.memWrt = 0; r.memRead = 0;
      r.halt = 0; r.regWrt = 0; r.err = 0; r.rd = '0; r.regSrc = '0;
      return r;
   endfunction

   task automatic randomizeInputs();
      bus.EX_ALU       = 16'($urandom);
      bus.EX_PC        = 16'($urandom);
      bus.EX_RTData    = 16'($urandom);
      bus.EX_MemWrt    = 1'($urandom);
      bus.EX_MemRead   = 1'($urandom);
      bus.EX_nHaltSig  = 1'($urandom);
      bus.EX_RegWrt    = 1'($urandom);
      bus.EX_err       = 1'($urandom);
      bus.EX_RD        = 3'($urandom);
      bus.EX_RegSrc    = 2'($urandom);
      bus.MEM_readData = 16'($urandom);
      bus.MMEM_err     = 1'($urandom);
   endtask

   task automatic compareAll();
      exRec_t ex;
      exRec_t wb;
      ex = hist[hist.size()-1];
      wb = hist[hist.size()-2];
      checkOutput("EXDM_ALU",      bus.EXDM_ALU,      ex.alu);
      checkOutput("EXDM_PC",       bus.EXDM_PC,       ex.pc);
      checkOutput("EXDM_RTData",   bus.EXDM_RTData,   ex.rt);
      checkOutput("EXDM_MemWrt",   bus.EXDM_MemWrt,   ex.memWrt);
      checkOutput("EXDM_MemRead",  bus.EXDM_MemRead,  ex.memRead);
      checkOutput("EXDM_HaltSig",  bus.EXDM_HaltSig,  ex.halt);
      checkOutput("EXDM_RegWrt",   bus.EXDM_RegWrt,   ex.regWrt);
      checkOutput("EXDM_err",      bus.EXDM_err,      ex.err);
      checkOutput("EXDM_RD",       bus.EXDM_RD,       ex.rd);
      checkOutput("EXDM_RegSrc",   bus.EXDM_RegSrc,   ex.regSrc);
      checkOutput("DMWB_ALU",      bus.DMWB_ALU,      wb.alu);
      checkOutput("DMWB_PC",       bus.DMWB_PC,       wb.pc);
      checkOutput("DMWB_readData", bus.DMWB_readData, modelReadData);
      checkOutput("DMWB_RegWrt",   bus.DMWB_RegWrt,   modelStalledWb ? 1'b0 : wb.regWrt);
      checkOutput("DMWB_RD",       bus.DMWB_RD,       wb.rd);
      checkOutput("DMWB_RegSrc",   bus.DMWB_RegSrc,   wb.regSrc);
      checkOutput("FWB_err",       bus.FWB_err,       wb.err);
      checkOutput("DMWB_err",      bus.DMWB_err,      modelStalledWb ? 1'b0 : modelMemErr);
   endtask

   // One clock edge with the given reset/Done_DM; the model follows the
   // edge and every output is compared 1 time unit after it.
   task automatic applyStimulus(input logic doRst, input logic done);
      rst         = doRst;
      bus.Done_DM = done;
      @(posedge clk);
      if (doRst) begin
         hist.delete();
         hist.push_back(zeroRec());
         hist.push_back(zeroRec());
         modelReadData  = '0;
         modelMemErr    = 1'b0;
         modelStalledWb = 1'b0;
      end else if (done) begin
         hist.push_back(sampleEx());
         if (hist.size() > 4) void'(hist.pop_front());
         modelReadData  = bus.MEM_readData;
         modelMemErr    = bus.MMEM_err;
         modelStalledWb = 1'b0;
      end else begin
`ifdef MEMWB_BUBBLE_EN
         modelStalledWb = 1'b1;
`else
         modelStalledWb = 1'b0;
`endif
      end
      #1;
      compareAll();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst = 1'b0;
      bus.Done_DM = 1'b0;

      // Reset with every input nonzero.
      bus.EX_ALU = 16'hFFFF; bus.EX_PC = 16'hAAAA; bus.EX_RTData = 16'h5555;
      bus.EX_MemWrt = 1; bus.EX_MemRead = 1; bus.EX_nHaltSig = 1;
      bus.EX_RegWrt = 1; bus.EX_err = 1; bus.EX_RD = 3'd7; bus.EX_RegSrc = 2'b11;
      bus.MEM_readData = 16'hFFFF; bus.MMEM_err = 1;
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst_exdmAlu", bus.EXDM_ALU, 16'h0000);
      checkOutput("rst_dmwbReadData", bus.DMWB_readData, 16'h0000);

      // Two-edge latency of an ALU result.
      randomizeInputs();
      bus.EX_ALU = 16'h1234; bus.EX_RD = 3'd3; bus.EX_RegWrt = 1; bus.EX_RegSrc = 2'b10;
      applyStimulus(1'b0, 1'b1);
      checkOutput("lat_exdmAlu", bus.EXDM_ALU, 16'h1234);
      randomizeInputs();
      applyStimulus(1'b0, 1'b1);
      checkOutput("lat_dmwbAlu", bus.DMWB_ALU, 16'h1234);
      checkOutput("lat_dmwbRd", bus.DMWB_RD, 3'd3);
      checkOutput("lat_dmwbRegSrc", bus.DMWB_RegSrc, 2'b10);

      // Load held across a 3-cycle stall, then completed with 16'hBEEF.
      randomizeInputs();
      bus.EX_MemRead = 1;
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         randomizeInputs();
         applyStimulus(1'b0, 1'b0);
      end
      randomizeInputs();
      bus.MEM_readData = 16'hBEEF;
      applyStimulus(1'b0, 1'b1);
      checkOutput("load_readData", bus.DMWB_readData, 16'hBEEF);

      // Error propagation from execute and from memory.
      randomizeInputs();
      bus.EX_err = 1; bus.MMEM_err = 0;
      applyStimulus(1'b0, 1'b1);
      checkOutput("err_exdm", bus.EXDM_err, 1'b1);
      randomizeInputs();
      bus.EX_err = 0; bus.MMEM_err = 1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("err_fwb", bus.FWB_err, 1'b1);
      checkOutput("err_dmwb", bus.DMWB_err, 1'b1);

      // Reset asserted in the middle of a stall.
      randomizeInputs();
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("stallRst_exdmPc", bus.EXDM_PC, 16'h0000);
      checkOutput("stallRst_dmwbPc", bus.DMWB_PC, 16'h0000);

      // Writeback enable behaviour while stalled.
      randomizeInputs();
      bus.EX_RegWrt = 1; bus.EX_RD = 3'd5;
      applyStimulus(1'b0, 1'b1);
      randomizeInputs();
      applyStimulus(1'b0, 1'b1);
      checkOutput("wb_regWrtBefore", bus.DMWB_RegWrt, 1'b1);
      randomizeInputs();
      applyStimulus(1'b0, 1'b0);
`ifdef MEMWB_BUBBLE_EN
      checkOutput("wb_regWrtStall", bus.DMWB_RegWrt, 1'b0);
`else
      checkOutput("wb_regWrtStall", bus.DMWB_RegWrt, 1'b1);
`endif
      checkOutput("wb_rdStall", bus.DMWB_RD, 3'd5);

      // Alternating Done_DM: only advancing edges move entries.
      for (int i = 0; i < 20; i++) begin
         randomizeInputs();
         applyStimulus(1'b0, 1'(i % 2));
      end

      // Random traffic with random stalls and occasional resets.
      for (int i = 0; i < 400; i++) begin
         randomizeInputs();
         applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
